// File: rtl/usb_burst_rw_sequencer.sv
// usb_burst_rw_sequencer: host-side command sequencer for the flash-drive host.
// Each command issues one address OUT and then len data IN/OUT transactions.
// Any transaction that fails is re-issued up to MAX_RETRY times.
// wr_ready pulses in the same cycle that the captured word goes out with trans_start.
// The write source should present word k and hold it until it sees the wr_ready for word k.
module usb_burst_rw_sequencer #(
    parameter int DATA_W    = 64,
    parameter int PAGE_W    = 16,
    parameter int BURST_MAX = 4,
    parameter int MAX_RETRY = 3,
    parameter int ADDR_ENDP = 4,
    parameter int DATA_ENDP = 8,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read_start,
    input  logic              write_start,
    input  logic [PAGE_W-1:0] mempage,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              finished,
    output logic              success,
    output logic [7:0]        retries,
    output logic              trans_start,
    output logic              trans_is_in,
    output logic [3:0]        trans_endp,
    output logic [DATA_W-1:0] trans_data,
    input  logic              trans_done,
    input  logic              trans_success,
    input  logic [DATA_W-1:0] trans_rd_data
);
    localparam int              RC_W    = $clog2(MAX_RETRY + 2);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BURST_MAX);
    localparam logic [3:0]      EP_ADDR = 4'(ADDR_ENDP);
    localparam logic [3:0]      EP_DATA = 4'(DATA_ENDP);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_ISSUE, S_ADDR_WAIT, S_DATA_ISSUE, S_DATA_WAIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic              wr_ready_q, wr_ready_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              finished_q, finished_d;
    logic              success_q, success_d;
    logic [7:0]        retries_q, retries_d;
    logic              trans_start_q, trans_start_d;
    logic              trans_is_in_q, trans_is_in_d;
    logic [3:0]        trans_endp_q, trans_endp_d;
    logic [DATA_W-1:0] trans_data_q, trans_data_d;

    // helper strobes shared by several state branches
    logic              issue_word;
    logic              retry_now;
    logic              end_cmd;
    logic              end_ok;
    logic [LEN_W-1:0]  word_nxt;

    assign wr_ready    = wr_ready_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign success     = success_q;
    assign retries     = retries_q;
    assign trans_start = trans_start_q;
    assign trans_is_in = trans_is_in_q;
    assign trans_endp  = trans_endp_q;
    assign trans_data  = trans_data_q;

    assign word_nxt = word_cnt_q + LEN_W'(1);

    // next-state and next-output logic; issue outputs are set on entry to *_ISSUE
    always_comb begin
        state_d       = state_q;
        is_wr_d       = is_wr_q;
        len_d         = len_q;
        word_cnt_d    = word_cnt_q;
        rc_d          = rc_q;
        wr_ready_d    = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        finished_d    = 1'b0;
        success_d     = success_q;
        retries_d     = retries_q;
        trans_start_d = 1'b0;
        trans_is_in_d = trans_is_in_q;
        trans_endp_d  = trans_endp_q;
        trans_data_d  = trans_data_q;
        issue_word    = 1'b0;
        retry_now     = 1'b0;
        end_cmd       = 1'b0;
        end_ok        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (read_start || write_start) begin
                    is_wr_d       = ~read_start;
                    len_d         = (burst_len == '0) ? LEN_W'(1) :
                                    (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
                    word_cnt_d    = '0;
                    rc_d          = '0;
                    retries_d     = '0;
                    success_d     = 1'b0;
                    trans_start_d = 1'b1;
                    trans_is_in_d = 1'b0;
                    trans_endp_d  = EP_ADDR;
                    trans_data_d  = {mempage, {(DATA_W-PAGE_W){1'b0}}};
                    state_d       = S_ADDR_ISSUE;
                end
            end
            S_ADDR_ISSUE: state_d = S_ADDR_WAIT;
            S_ADDR_WAIT: begin
                if (trans_done) begin
                    if (trans_success) begin
                        rc_d       = '0;
                        issue_word = 1'b1;
                    end else if (rc_q < RC_MAX) begin
                        retry_now = 1'b1;
                        state_d   = S_ADDR_ISSUE;
                    end else begin
                        end_cmd = 1'b1;
                    end
                end
            end
            S_DATA_ISSUE: state_d = S_DATA_WAIT;
            S_DATA_WAIT: begin
                if (trans_done) begin
                    if (trans_success) begin
                        rc_d       = '0;
                        word_cnt_d = word_nxt;
                        if (!is_wr_q) begin
                            rd_data_d  = trans_rd_data;
                            rd_valid_d = 1'b1;
                        end
                        if (word_nxt == len_q) begin
                            end_cmd = 1'b1;
                            end_ok  = 1'b1;
                        end else begin
                            issue_word = 1'b1;
                        end
                    end else if (rc_q < RC_MAX) begin
                        retry_now = 1'b1;
                        state_d   = S_DATA_ISSUE;
                    end else begin
                        end_cmd = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // first issue of a data word: a write captures a fresh word and acknowledges it
        if (issue_word) begin
            state_d       = S_DATA_ISSUE;
            trans_start_d = 1'b1;
            trans_endp_d  = EP_DATA;
            trans_is_in_d = ~is_wr_q;
            if (is_wr_q) begin
                trans_data_d = wr_data;
                wr_ready_d   = 1'b1;
            end
        end
        // a retry re-sends the held payload unchanged
        if (retry_now) begin
            trans_start_d = 1'b1;
            rc_d          = rc_q + RC_W'(1);
            retries_d     = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
        end
        if (end_cmd) begin
            state_d    = S_DONE;
            finished_d = 1'b1;
            success_d  = end_ok;
        end

        busy_d = (state_d != S_IDLE);
    end

    // state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            is_wr_q       <= 1'b0;
            len_q         <= '0;
            word_cnt_q    <= '0;
            rc_q          <= '0;
            wr_ready_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            success_q     <= 1'b0;
            retries_q     <= '0;
            trans_start_q <= 1'b0;
            trans_is_in_q <= 1'b0;
            trans_endp_q  <= '0;
            trans_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            is_wr_q       <= is_wr_d;
            len_q         <= len_d;
            word_cnt_q    <= word_cnt_d;
            rc_q          <= rc_d;
            wr_ready_q    <= wr_ready_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            success_q     <= success_d;
            retries_q     <= retries_d;
            trans_start_q <= trans_start_d;
            trans_is_in_q <= trans_is_in_d;
            trans_endp_q  <= trans_endp_d;
            trans_data_q  <= trans_data_d;
        end
    end

endmodule

// File: tb/tb_usb_burst_rw_sequencer.sv
// tb_usb_burst_rw_sequencer: directed and randomized commands against a
// transaction-list model of one command (address OUT, then len data words with retries).
module tb_usb_burst_rw_sequencer;
    localparam int DATA_W    = 64;
    localparam int PAGE_W    = 16;
    localparam int BURST_MAX = 4;
    localparam int MAX_RETRY = 3;
    localparam int LEN_W     = 3;

    logic              clock;
    logic              reset;
    logic              read_start, write_start;
    logic [PAGE_W-1:0] mempage;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, busy, finished, success;
    logic [7:0]        retries;
    logic              trans_start, trans_is_in;
    logic [3:0]        trans_endp;
    logic [DATA_W-1:0] trans_data;
    logic              trans_done, trans_success;
    logic [DATA_W-1:0] trans_rd_data;

    usb_burst_rw_sequencer #(
        .DATA_W(DATA_W), .PAGE_W(PAGE_W), .BURST_MAX(BURST_MAX), .MAX_RETRY(MAX_RETRY),
        .ADDR_ENDP(4), .DATA_ENDP(8), .LEN_W(LEN_W)
    ) dut (
        .clock(clock), .reset(reset), .read_start(read_start), .write_start(write_start),
        .mempage(mempage), .burst_len(burst_len), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .finished(finished),
        .success(success), .retries(retries), .trans_start(trans_start),
        .trans_is_in(trans_is_in), .trans_endp(trans_endp), .trans_data(trans_data),
        .trans_done(trans_done), .trans_success(trans_success), .trans_rd_data(trans_rd_data)
    );

    typedef struct {
        logic        is_in;
        logic [3:0]  endp;
        logic [63:0] data;
    } tx_t;

    int          n_chk = 0;
    int          n_err = 0;
    // observations (monitor is the only writer)
    tx_t         obs_tx[$];
    logic [63:0] obs_rd[$];
    int          wr_cnt = 0;
    int          fin_cnt = 0;
    logic        fin_success;
    logic [7:0]  fin_retries;
    // stimulus plans (main thread is the only writer)
    logic [63:0] wr_words[$];
    int          wr_base = 0;
    logic        out_plan[$];
    logic [63:0] rd_plan[$];
    logic        eng_hold = 1'b0;
    int          plan_f[5];
    logic [63:0] cmd_words[4];
    // engine read pointers (engine is the only writer)
    int          eng_op = 0;
    int          eng_rp = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor: sample DUT outputs at the falling edge, feed write words
    initial begin
        wr_data = '0;
        forever begin
            @(negedge clock);
            if (trans_start) begin
                tx_t t;
                t.is_in = trans_is_in;
                t.endp  = trans_endp;
                t.data  = trans_data;
                obs_tx.push_back(t);
            end
            if (wr_ready) wr_cnt++;
            if (rd_valid) obs_rd.push_back(rd_data);
            if (finished) begin
                fin_cnt++;
                fin_success = success;
                fin_retries = retries;
            end
            wr_data = (wr_cnt - wr_base < wr_words.size()) ? wr_words[wr_cnt - wr_base] : '0;
        end
    end

    // transaction engine: answers each trans_start after a random delay using out_plan
    initial begin
        int   d;
        logic ok;
        trans_done    = 1'b0;
        trans_success = 1'b0;
        trans_rd_data = '0;
        forever begin
            if (trans_start && !(eng_hold && trans_is_in)) begin
                ok = 1'b1;
                if (eng_op < out_plan.size()) begin
                    ok = out_plan[eng_op];
                    eng_op++;
                end
                d = $urandom_range(0, 2);
                repeat (d + 1) @(negedge clock);
                trans_done    = 1'b1;
                trans_success = ok;
                if (ok && trans_is_in && eng_rp < rd_plan.size()) begin
                    trans_rd_data = rd_plan[eng_rp];
                    eng_rp++;
                end else begin
                    trans_rd_data = {$urandom, $urandom};
                end
                @(negedge clock);
                trans_done    = 1'b0;
                trans_success = 1'($urandom_range(0, 1));
            end else begin
                @(negedge clock);
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 5; i++) plan_f[i] = 0;
        for (int i = 0; i < 4; i++) cmd_words[i] = {$urandom, $urandom};
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " finished"}, 64'(finished), 0);
        chk({tag, " success"}, 64'(success), 0);
        chk({tag, " retries"}, 64'(retries), 0);
        chk({tag, " trans_start"}, 64'(trans_start), 0);
        chk({tag, " trans_is_in"}, 64'(trans_is_in), 0);
        chk({tag, " trans_endp"}, 64'(trans_endp), 0);
        chk({tag, " trans_data"}, trans_data, 0);
        chk({tag, " rd_valid"}, 64'(rd_valid), 0);
        chk({tag, " rd_data"}, rd_data, 0);
        chk({tag, " wr_ready"}, 64'(wr_ready), 0);
    endtask

    // one command: model the expected transaction list, run it, compare
    task automatic run_cmd(input logic rs, input logic ws, input logic [15:0] page,
                           input logic [2:0] blen, input string tag);
        tx_t         exp_tx[$];
        logic [63:0] exp_rd[$];
        tx_t         t;
        logic [63:0] w;
        int          len, att, rtr, nwr, tb0, rb0, fb0, cyc;
        logic        ok_all, is_rd;
        is_rd  = rs;
        len    = (blen == 0) ? 1 : ((int'(blen) > BURST_MAX) ? BURST_MAX : int'(blen));
        rtr    = 0;
        nwr    = 0;
        ok_all = 1'b1;
        wr_words.delete();
        for (int k = 0; k < 4; k++) wr_words.push_back(cmd_words[k]);
        wr_base = wr_cnt;
        for (int ti = 0; ti <= len && ok_all; ti++) begin
            att = (plan_f[ti] > MAX_RETRY) ? MAX_RETRY + 1 : plan_f[ti] + 1;
            if (ti > 0 && !is_rd) nwr++;
            for (int a = 0; a < att; a++) begin
                t.is_in = (ti > 0) && is_rd;
                t.endp  = (ti == 0) ? 4'd4 : 4'd8;
                t.data  = (ti == 0) ? {page, 48'h0} : (is_rd ? 64'h0 : cmd_words[ti-1]);
                exp_tx.push_back(t);
                out_plan.push_back(a >= plan_f[ti]);
            end
            rtr += att - 1;
            if (plan_f[ti] > MAX_RETRY) begin
                ok_all = 1'b0;
            end else if (ti > 0 && is_rd) begin
                w = {$urandom, $urandom};
                rd_plan.push_back(w);
                exp_rd.push_back(w);
            end
        end
        tb0 = obs_tx.size();
        rb0 = obs_rd.size();
        fb0 = fin_cnt;

        @(negedge clock);
        read_start  = rs;
        write_start = ws;
        mempage     = page;
        burst_len   = blen;
        @(negedge clock);
        read_start  = 1'b0;
        write_start = 1'b0;
        mempage     = 16'($urandom);
        burst_len   = 3'($urandom);
        // starts while busy must be ignored
        repeat (2) @(negedge clock);
        read_start  = 1'b1;
        write_start = 1'b1;
        @(negedge clock);
        read_start  = 1'b0;
        write_start = 1'b0;

        cyc = 0;
        while (fin_cnt == fb0 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        if (fin_cnt == fb0) begin
            chk({tag, " timeout"}, 0, 1);
            reset = 1'b1;
            repeat (2) @(negedge clock);
            reset = 1'b0;
        end
        repeat (3) @(negedge clock);

        chk({tag, " n_tx"}, 64'(obs_tx.size() - tb0), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && tb0 + i < obs_tx.size(); i++) begin
            chk({tag, " tx_is_in"}, 64'(obs_tx[tb0+i].is_in), 64'(exp_tx[i].is_in));
            chk({tag, " tx_endp"}, 64'(obs_tx[tb0+i].endp), 64'(exp_tx[i].endp));
            if (!exp_tx[i].is_in) chk({tag, " tx_data"}, obs_tx[tb0+i].data, exp_tx[i].data);
        end
        chk({tag, " n_rd"}, 64'(obs_rd.size() - rb0), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && rb0 + i < obs_rd.size(); i++)
            chk({tag, " rd_data"}, obs_rd[rb0+i], exp_rd[i]);
        chk({tag, " n_wr_ready"}, 64'(wr_cnt - wr_base), 64'(nwr));
        chk({tag, " n_finished"}, 64'(fin_cnt - fb0), 1);
        chk({tag, " fin_success"}, 64'(fin_success), 64'(ok_all));
        chk({tag, " fin_retries"}, 64'(fin_retries), 64'(rtr));
        chk({tag, " held_success"}, 64'(success), 64'(ok_all));
        chk({tag, " held_retries"}, 64'(retries), 64'(rtr));
        chk({tag, " busy_after"}, 64'(busy), 0);
    endtask

    // reset while a data IN is outstanding, then a normal read
    task automatic reset_test();
        int tb0, fb0, cyc;
        tb0      = obs_tx.size();
        fb0      = fin_cnt;
        eng_hold = 1'b1;
        @(negedge clock);
        read_start = 1'b1;
        mempage    = 16'h5A5A;
        burst_len  = 3'd2;
        @(negedge clock);
        read_start = 1'b0;
        cyc = 0;
        while (obs_tx.size() < tb0 + 2 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("rst reached data IN", 64'(obs_tx.size() - tb0), 2);
        repeat (2) @(negedge clock);
        chk("rst busy before", 64'(busy), 1);
        reset = 1'b1;
        #1;
        chk_idle_zero("rst async");
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        eng_hold = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst no finished", 64'(fin_cnt - fb0), 0);
        chk("rst idle", 64'(busy), 0);
        clear_plan();
        run_cmd(1'b1, 1'b0, 16'h0042, 3'd2, "post_rst");
    endtask

    initial begin
        logic rs, ws;
        reset       = 1'b1;
        read_start  = 1'b0;
        write_start = 1'b0;
        mempage     = '0;
        burst_len   = '0;
        repeat (3) @(negedge clock);
        chk_idle_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        clear_plan();
        run_cmd(1'b1, 1'b0, 16'h00AB, 3'd1, "rd1");

        clear_plan();
        cmd_words[0] = 64'h1; cmd_words[1] = 64'h2; cmd_words[2] = 64'h3;
        run_cmd(1'b0, 1'b1, 16'h1234, 3'd3, "wr3");

        clear_plan();
        plan_f[1] = 2;
        run_cmd(1'b0, 1'b1, 16'h0777, 3'd1, "wr_retry2");

        clear_plan();
        plan_f[0] = 4;
        run_cmd(1'b1, 1'b0, 16'hBEEF, 3'd2, "addr_fail");

        clear_plan();
        run_cmd(1'b1, 1'b1, 16'h0101, 3'd0, "both_len0");

        clear_plan();
        run_cmd(1'b1, 1'b0, 16'h0202, 3'd7, "rd_len7");

        clear_plan();
        plan_f[2] = 4;
        run_cmd(1'b0, 1'b1, 16'h0303, 3'd3, "wr_abort");

        reset_test();

        for (int n = 0; n < 40; n++) begin
            clear_plan();
            for (int i = 0; i < 5; i++)
                plan_f[i] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
            rs = 1'($urandom_range(0, 1));
            ws = rs ? 1'($urandom_range(0, 1)) : 1'b1;
            run_cmd(rs, ws, 16'($urandom), 3'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
